// File: rtl/sr_sched_pkg.sv
// Shared encodings and helpers for the SR flag scheduler and its arbiter.
package sr_sched_pkg;

  typedef enum logic [1:0] {
    CMD_NOP = 2'b00,
    CMD_SET = 2'b01,
    CMD_CLR = 2'b10,
    CMD_TGL = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // Width needed to encode n distinct values, never less than one bit.
  function automatic int ptr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter
  import sr_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_grant
);

  int unsigned pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    pos       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      if (!any_grant && req[pos]) begin
        any_grant      = 1'b1;
        grant[pos]     = 1'b1;
        grant_idx      = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/sr_flag_scheduler.sv
// Round-robin scheduler owning the s/r lines of a shared SR flag bank.
// Handshake: a requester holds req_valid/cmd/idx stable until its one-cycle req_ready pulse and must drop or replace the request by the following edge; requests are only sampled in IDLE.
module sr_flag_scheduler
  import sr_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_FLAGS = 8,
  parameter int IDX_W     = ptr_w(NUM_FLAGS),
  parameter int PULSE_CYC = 1,
  localparam int ID_W     = ptr_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_cmd,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_FLAGS-1:0]     q_in,
  output logic [NUM_FLAGS-1:0]     s_out,
  output logic [NUM_FLAGS-1:0]     r_out,
  output logic                     busy,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic                     err_verify,
  output logic                     err_idx
);

  localparam int CNT_W = 2;

  state_e               state;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      id_r;
  logic [NUM_FLAGS-1:0] mask_r;
  logic                 exp_q;
  logic                 check_en;
  logic [CNT_W-1:0]     cnt;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      gnt_idx;
  logic                 any_grant;

  cmd_e                 win_cmd;
  logic [IDX_W-1:0]     win_idx;
  logic                 idx_ok;
  logic [NUM_FLAGS-1:0] flag_mask;
  logic                 win_q;
  logic                 do_set;
  logic                 do_drive;
  logic [ID_W-1:0]      next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gnt_idx),
    .any_grant (any_grant)
  );

  // An out-of-range index shifts the mask to zero, so no flop is ever addressed.
  always_comb begin
    win_cmd   = cmd_e'(req_cmd[2*int'(gnt_idx) +: 2]);
    win_idx   = req_idx[int'(gnt_idx)*IDX_W +: IDX_W];
    idx_ok    = (int'(win_idx) < NUM_FLAGS);
    flag_mask = {{(NUM_FLAGS-1){1'b0}}, 1'b1} << win_idx;
    win_q     = |(q_in & flag_mask);
    do_set    = (win_cmd == CMD_SET) || ((win_cmd == CMD_TGL) && !win_q);
    do_drive  = (win_cmd != CMD_NOP) && idx_ok;
    next_ptr  = (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      id_r       <= '0;
      mask_r     <= '0;
      exp_q      <= 1'b0;
      check_en   <= 1'b0;
      cnt        <= '0;
      s_out      <= '0;
      r_out      <= '0;
      req_ready  <= '0;
      done       <= 1'b0;
      done_id    <= '0;
      err_verify <= 1'b0;
      err_idx    <= 1'b0;
    end else begin
      req_ready <= '0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (any_grant) begin
            req_ready <= grant;
            id_r      <= gnt_idx;
            ptr       <= next_ptr;
            mask_r    <= flag_mask;
            exp_q     <= do_set;
            if (!idx_ok) err_idx <= 1'b1;
            if (do_drive) begin
              state    <= DRIVE;
              s_out    <= do_set ? flag_mask : '0;
              r_out    <= do_set ? '0 : flag_mask;
              cnt      <= CNT_W'(PULSE_CYC - 1);
              check_en <= 1'b1;
            end else begin
              state    <= SETTLE;
              done     <= 1'b1;
              done_id  <= gnt_idx;
              check_en <= 1'b0;
            end
          end
        end
        DRIVE: begin
          if (cnt == '0) begin
            state   <= SETTLE;
            s_out   <= '0;
            r_out   <= '0;
            done    <= 1'b1;
            done_id <= id_r;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETTLE: begin
          state <= IDLE;
          if (check_en && ((|(q_in & mask_r)) != exp_q)) err_verify <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_flag_scheduler.sv
// Directed bench for sr_flag_scheduler with a behavioural SR bank on q_in.
module tb_sr_flag_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [7:0]  req_cmd;
  logic [15:0] req_idx;
  logic [3:0]  req_ready;
  logic [7:0]  q_in;
  logic [7:0]  s_out;
  logic [7:0]  r_out;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic        err_verify;
  logic        err_idx;

  logic [7:0]  bank = '0;
  logic        hold;
  logic        load_en;
  logic [7:0]  load_val;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int         r;
    logic [1:0] cmd;
    logic [3:0] idx;
    bit         hold;
    logic [7:0] s;
    logic [7:0] rr;
    bit         drive;
    bit         ev;
    bit         ei;
  } vec_t;

  vec_t vecs[11];

  sr_flag_scheduler #(
    .NUM_REQ   (4),
    .NUM_FLAGS (8),
    .IDX_W     (4),
    .PULSE_CYC (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_cmd    (req_cmd),
    .req_idx    (req_idx),
    .req_ready  (req_ready),
    .q_in       (q_in),
    .s_out      (s_out),
    .r_out      (r_out),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id),
    .err_verify (err_verify),
    .err_idx    (err_idx)
  );

  always #5 clk = ~clk;

  // Behavioural SR bank; hold freezes it to model a stuck flop.
  always @(posedge clk) begin
    if (load_en) bank <= load_val;
    else if (!hold) bank <= (bank | s_out) & ~r_out;
  end
  assign q_in = bank;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_ready(output bit got, inout int cyc);
    got = 1'b0;
    for (int w = 0; w < 12 && !got; w++) begin
      step();
      cyc++;
      if (req_ready != '0) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic do_op(input vec_t v);
    bit got;
    int cyc;
    cyc = 0;
    hold = v.hold;
    req_valid = '0;
    req_valid[v.r] = 1'b1;
    req_cmd[2*v.r +: 2] = v.cmd;
    req_idx[4*v.r +: 4] = v.idx;
    wait_ready(got, cyc);
    req_valid = '0;
    if (got) begin
      chk("ready", 32'(req_ready), 32'(1 << v.r));
      chk("s_drive", 32'(s_out), 32'(v.s));
      chk("r_drive", 32'(r_out), 32'(v.rr));
      if (v.drive) begin
        chk("busy_drive", 32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
        step();
        chk("s_settle", 32'(s_out), 32'd0);
        chk("r_settle", 32'(r_out), 32'd0);
      end
      chk("done", 32'(done), 32'd1);
      chk("done_id", 32'(done_id), 32'(v.r));
      step();
      chk("done_pulse", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("err_verify", 32'(err_verify), 32'(v.ev));
      chk("err_idx", 32'(err_idx), 32'(v.ei));
    end
    hold = 1'b0;
  endtask

  initial begin
    bit got;
    int cyc;
    int last;
    int viol;

    //          r  cmd    idx   hold s      r      drive ev ei
    vecs[0]  = '{0, 2'b01, 4'd5, 0, 8'h20, 8'h00, 1, 0, 0};
    vecs[1]  = '{2, 2'b11, 4'd1, 0, 8'h00, 8'h02, 1, 0, 0};
    vecs[2]  = '{2, 2'b11, 4'd1, 0, 8'h02, 8'h00, 1, 0, 0};
    vecs[3]  = '{3, 2'b10, 4'd5, 0, 8'h00, 8'h20, 1, 0, 0};
    vecs[4]  = '{1, 2'b00, 4'd0, 0, 8'h00, 8'h00, 0, 0, 0};
    vecs[5]  = '{1, 2'b01, 4'd7, 0, 8'h80, 8'h00, 1, 0, 0};
    vecs[6]  = '{0, 2'b10, 4'd7, 0, 8'h00, 8'h80, 1, 0, 0};
    vecs[7]  = '{1, 2'b01, 4'd9, 0, 8'h00, 8'h00, 0, 0, 1};
    vecs[8]  = '{3, 2'b10, 4'd0, 0, 8'h00, 8'h01, 1, 0, 1};
    vecs[9]  = '{0, 2'b01, 4'd0, 1, 8'h01, 8'h00, 1, 1, 1};
    vecs[10] = '{2, 2'b10, 4'd1, 0, 8'h00, 8'h02, 1, 1, 1};

    rst_n = 1'b0;
    req_valid = '0;
    req_cmd = '0;
    req_idx = '0;
    hold = 1'b0;
    load_en = 1'b0;
    load_val = '0;
    step();
    step();
    chk("rst_s", 32'(s_out), 32'd0);
    chk("rst_r", 32'(r_out), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_err_verify", 32'(err_verify), 32'd0);
    chk("rst_err_idx", 32'(err_idx), 32'd0);
    #3 rst_n = 1'b1;

    load_en = 1'b1;
    load_val = 8'h02;
    step();
    load_en = 1'b0;

    for (int i = 0; i < 11; i++) do_op(vecs[i]);

    // Round robin with all four requesting: requester i sets flag i+2.
    rst_n = 1'b0;
    step();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_cmd[2*i +: 2] = 2'b01;
      req_idx[4*i +: 4] = 4'(i + 2);
    end
    req_valid = 4'hf;
    cyc = 0;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ready(got, cyc);
      if (got) begin
        chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
        chk("rr_s", 32'(s_out), 32'(1 << ((k % 4) + 2)));
        if (k > 0) chk("rr_gap", 32'(cyc - last), 32'd3);
        last = cyc;
        step();
        cyc++;
        chk("rr_pulse", 32'(req_ready), 32'd0);
      end
    end
    req_valid = '0;
    repeat (3) step();

    // Reset in the middle of a drive of flag 3 by requester 1.
    req_valid = 4'b0010;
    req_cmd[3:2] = 2'b01;
    req_idx[7:4] = 4'd3;
    wait_ready(got, cyc);
    req_valid = '0;
    chk("mid_s_before", 32'(s_out), 32'h08);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_s", 32'(s_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    step();
    chk("mid_rst_done", 32'(done), 32'd0);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_done", 32'(done), 32'd0);
    req_cmd[5:4] = 2'b01;
    req_idx[11:8] = 4'd6;
    req_valid = 4'b0110;
    wait_ready(got, cyc);
    req_valid = '0;
    chk("post_rst_ptr", 32'(req_ready), 32'b0010);
    repeat (3) step();

    // Random traffic: s and r must stay disjoint and at most one line high.
    viol = 0;
    for (int c = 0; c < 10000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_cmd = 8'($urandom);
      req_idx = 16'($urandom);
      step();
      if (((s_out & r_out) != '0) || ($countones(s_out | r_out) > 1)) viol++;
    end
    req_valid = '0;
    chk("safety", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sr_flag_scheduler.md
Name: sr_flag_scheduler

Overview:
- Round-robin scheduler sharing one bank of clocked SR flip-flops (flag register) between several requesters.
- Each requester issues a set, clear or toggle command for one flag index.
- The block arbitrates and drives exactly one s or r line per operation, never s=r=1. It then checks the flop's q and reports completion.
- Sits between control agents and the SR flag bank; owns all s/r lines of that bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_FLAGS, 8, number of SR flops in the bank.
- IDX_W, $clog2(NUM_FLAGS) (min 1), flag index width.
- PULSE_CYC, 1, cycles s or r is held high per operation (1..4).

Ports:
- clk  in  1  rising-edge clock shared with the SR bank.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_cmd  in  2*NUM_REQ  per-requester command, slice i = [2i+1:2i]. 00 nop, 01 set, 10 clear, 11 toggle.
- req_idx  in  NUM_REQ*IDX_W  per-requester flag index.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- q_in  in  NUM_FLAGS  current q of every SR flop.
- s_out  out  NUM_FLAGS  set lines to the bank.
- r_out  out  NUM_FLAGS  reset lines to the bank.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- done_id  out  $clog2(NUM_REQ) (min 1)  requester served, valid with done.
- err_verify  out  1  sticky: post-drive q mismatch.
- err_idx  out  1  sticky: out-of-range index accepted.

Behaviour:
- Reset (async, rst_n=0):
  - Immediately force s_out=0, r_out=0, req_ready=0, busy=0, done=0, done_id=0, err_verify=0, err_idx=0.
  - State=IDLE, round-robin pointer=0.
  - The SR bank itself is not reset by this block.
  - Reset mid-DRIVE truncates the pulse; no done is issued for that operation.
- States: IDLE, DRIVE, SETTLE.
- IDLE, at edge T with any req_valid high:
  - Winner = first valid at or after the pointer, wrapping.
  - Latch the winner's cmd and idx; req_ready[winner]=1 for cycle T+1 only.
  - Pointer = winner+1 mod NUM_REQ.
  - Toggle: sample q_in[idx] at edge T. q=1 becomes clear, q=0 becomes set.
  - nop, or idx >= NUM_FLAGS: no drive. Go straight to SETTLE with the check skipped. err_idx is set if idx is out of range.
  - Otherwise go to DRIVE.
- DRIVE, cycles T+1 .. T+PULSE_CYC:
  - Exactly one line is high: s_out[idx] for set, r_out[idx] for clear.
  - All other s/r bits are 0.
  - s_out & r_out == 0 at all times.
- SETTLE, one cycle:
  - All s/r low.
  - Compare q_in[idx] to the expected value (1 for set, 0 for clear); mismatch sets err_verify.
  - done=1, done_id=winner. Next state IDLE.
- Latency:
  - Drive operation: accept edge T to done in cycle T+PULSE_CYC+1.
  - nop/bad index: done in cycle T+1.
  - Next accept no earlier than the edge ending the SETTLE cycle.
- Handshake:
  - Requester holds valid, cmd and idx stable until it sees req_ready.
  - It must drop valid, or present a new request, by the edge after req_ready.
  - Valid deasserted before accept means the request is withdrawn; no side effect.
- Simultaneous requests are resolved by the pointer only; no fixed priority.
- Any number of requesters may target the same flag; operations are serialised.
- Changes on req_* while busy are ignored.
- err_verify and err_idx clear only on reset.

Decomposition:
- Shared package sr_sched_pkg holds:
  - Command encodings CMD_NOP, CMD_SET, CMD_CLR, CMD_TGL.
  - State enum IDLE/DRIVE/SETTLE.
  - The pointer-width function.
- Sub-module rr_arbiter:
  - Inputs: NUM_REQ request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-grant.
  - Purely combinational, reusable by other schedulers.

Test Plan:
- Reset: rst_n low mid-DRIVE with s_out[3]=1 -> s_out=0 immediately; busy=0; no done; after release, the first accept uses the pointer value 0.
- Single set: req 0 set idx 5, q_in[5]=0, PULSE_CYC=1 -> req_ready=0001 at T+1; s_out=0x20 at T+1; SETTLE at T+2 with q_in[5]=1; done=1, done_id=0, err_verify=0.
- Round robin: all four valid each cycle, pointer=0 -> grant order 0,1,2,3,0; each req_ready is a one-cycle pulse; operations are 3 cycles apart.
- Toggle: req 2 toggle idx 1 with q_in[1]=1 -> r_out=0x02 for one cycle, s_out=0; then toggle again with q_in[1]=0 -> s_out=0x02.
- Errors: req 1 set idx 9 with NUM_FLAGS=8 (IDX_W=4 build) -> no s/r activity, err_idx=1, done at T+1. Separately, hold q_in[0]=0 during a set of idx 0 -> err_verify=1, which stays high until reset.
- Safety: across 10k random cycles, assert s_out & r_out == 0 always, and $countones(s_out|r_out) <= 1.
